fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
//
// PURPOSE
//   Shares the single write port of one fifo instance among N_REQ requesters.
//   Round-robin arbitration with burst locking: a granted requester keeps the port for up to MAX_BURST beats.
//   Sits between producer blocks (valid/ready) and the fifo write side (wr_en/data_in/full).
//   Tags each beat with the granted requester index so the read side can demux by source.
//
// PARAMETERS
//   N_REQ      4   number of requesters (>=2)
//   WIDTH      4   data width; equals the fifo WIDTH
//   MAX_BURST  4   max beats per grant (>=1); ID_W = $clog2(N_REQ), CNT_W = $clog2(MAX_BURST+1)
//
// PORTS
//   clk           in   1            single clock, rising edge
//   rst           in   1            asynchronous, active-high reset
//   req_valid     in   N_REQ        per-requester data valid
//   req_data      in   N_REQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]
//   req_ready     out  N_REQ        per-requester accept; at most one bit high
//   fifo_full     in   1            fifo full flag
//   fifo_wr_en    out  1            fifo write enable
//   fifo_wr_data  out  WIDTH        fifo write data
//   grant_id      out  ID_W         index of current/last granted requester
//   busy          out  1            high while in GRANT
//
// BEHAVIOUR
//   - Reset (async, immediate): state=IDLE, grant_id=0, last_grant=N_REQ-1 (requester 0 wins first),
//     beat_cnt=0; req_ready=0, fifo_wr_en=0, fifo_wr_data=0, busy=0 while rst high and in IDLE.
//   - FSM states: IDLE, GRANT. All outputs are combinational from registered state + current inputs.
//   - IDLE: no req_ready. If any req_valid at the edge: pick the first valid index searching
//     last_grant+1, +2, ... mod N_REQ; register grant_id and last_grant, beat_cnt=0, go GRANT.
//   - GRANT (g = grant_id): req_ready[g] = !fifo_full; fifo_wr_en = req_valid[g] && !fifo_full;
//     fifo_wr_data = req_data[g] (0 when not writing). Beat = req_valid[g] && req_ready[g].
//   - GRANT exit at edge: (beat && beat_cnt==MAX_BURST-1) -> IDLE; else (!req_valid[g]) -> IDLE;
//     else stay, beat_cnt += beat.
//   - Latency: req_valid rising before edge k -> grant at edge k -> first write at edge k+1.
//     One IDLE cycle between consecutive grants (no back-to-back grant).
//   - fifo_full during GRANT: stall, grant held indefinitely, beat_cnt frozen; no timeout.
//   - Requester dropping valid mid-burst releases the port; no partial beat is written.
//   - Other requesters' valid/data are ignored while in GRANT; never drop a granted beat.
//   - Round-robin pointer wraps N_REQ-1 -> 0; only valid requesters are considered.
//   - Reset mid-burst: beats already accepted stay in the fifo; the current beat is not written.
//   - grant_id holds last granted index in IDLE (not cleared).
//
// STRUCTURE
//   - fifo_arb_pkg: state enum {IDLE, GRANT}; helper for ID_W/CNT_W widths.
//   - Sub-module rr_priority_pick (combinational): inputs req mask + last_grant, outputs
//     any_req and winner index; reused by future fifo read-side schedulers.
//   - Top holds FSM, grant/last_grant/beat_cnt registers and output muxing.
//
// TESTING
//   1. Reset: rst=1 mid-burst with req_valid=4'b1111 -> same cycle fifo_wr_en=0, req_ready=0, busy=0.
//   2. Single requester: req_valid=4'b0100, data 0xA,0xB,0xC -> grant_id=2 after 1 cycle,
//      fifo sees A,B,C on consecutive edges, then IDLE when valid drops.
//   3. Fairness: all 4 valid continuously, MAX_BURST=4 -> grants 0,1,2,3,0; exactly 4 beats each,
//      one idle cycle between grants.
//   4. Full stall: grant=1, fifo_full=1 for 5 cycles after beat 2 -> no writes, req_ready[1]=0,
//      grant held; after full drops beats 3,4 written, then release.
//   5. Early release: requester 3 valid for 2 beats only -> 2 writes, IDLE, next pick
//      searches from 0.
//   6. Wrap: last_grant=3, req_valid=4'b0011 -> grant 0; then grant 1 next.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and width helper for fifo write-side arbitration
package fifo_arb_pkg;

   typedef enum logic {IDLE, GRANT} state_t;

   function automatic int clog2_min1(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational round-robin pick, first set req bit after last_grant
module rr_priority_pick #(
   parameter int N    = 4,
   parameter int ID_W = 2
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] last_grant,
   output logic            any_req,
   output logic [ID_W-1:0] winner
);

   int   idx;
   logic found;

   always_comb begin
      any_req = |req;
      winner  = '0;
      found   = 1'b0;
      idx     = 0;
      for (int i = 1; i <= N; i++) begin
         idx = (int'(last_grant) + i) % N;
         if (!found && req[idx]) begin
            winner = ID_W'(idx);
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-locked sharing of one fifo write port
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int N_REQ     = 4,
   parameter  int WIDTH     = 4,
   parameter  int MAX_BURST = 4,
   localparam int ID_W      = clog2_min1(N_REQ),
   localparam int CNT_W     = clog2_min1(MAX_BURST + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]       req_ready,
   input  logic                   fifo_full,
   output logic                   fifo_wr_en,
   output logic [WIDTH-1:0]       fifo_wr_data,
   output logic [ID_W-1:0]        grant_id,
   output logic                   busy
);

   state_t           state;
   logic [ID_W-1:0]  last_grant;
   logic [ID_W-1:0]  winner;
   logic [CNT_W-1:0] beat_cnt;
   logic             any_req;
   logic             in_grant;
   logic             g_valid;
   logic             beat;
   logic [WIDTH-1:0] g_data;

   rr_priority_pick #(.N(N_REQ), .ID_W(ID_W)) u_pick (
      .req       (req_valid),
      .last_grant(last_grant),
      .any_req   (any_req),
      .winner    (winner)
   );

   always_comb begin
      in_grant     = state == GRANT;
      g_valid      = req_valid[grant_id];
      g_data       = req_data[grant_id*WIDTH +: WIDTH];
      beat         = in_grant && g_valid && !fifo_full;
      req_ready    = (in_grant && !fifo_full) ? N_REQ'(1) << grant_id : '0;
      fifo_wr_en   = beat;
      fifo_wr_data = beat ? g_data : '0;
      busy         = in_grant;
   end

   // last_grant starts at N_REQ-1 so requester 0 wins the first arbitration
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         grant_id   <= '0;
         last_grant <= ID_W'(N_REQ - 1);
         beat_cnt   <= '0;
      end else if (state == IDLE) begin
         if (any_req) begin
            state      <= GRANT;
            grant_id   <= winner;
            last_grant <= winner;
            beat_cnt   <= '0;
         end
      end else if (beat && beat_cnt == CNT_W'(MAX_BURST - 1)) begin
         state <= IDLE;
      end else if (!g_valid) begin
         state <= IDLE;
      end else begin
         beat_cnt <= beat_cnt + CNT_W'(beat);
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed producers feed the arbiter; a monitor scores each fifo write
module tb_fifo_wr_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [15:0] req_data;
   logic [3:0]  req_ready;
   logic        fifo_full;
   logic        fifo_wr_en;
   logic [3:0]  fifo_wr_data;
   logic [1:0]  grant_id;
   logic        busy;

   logic [3:0] src_data [4][16];
   logic [4:0] src_len  [4];
   logic [4:0] src_ptr  [4];
   logic [3:0] acc;
   logic [5:0] exp_q [$];
   int         passed;
   int         total;
   int         wr_count;
   int         w0;

   fifo_wr_arbiter #(.N_REQ(4), .WIDTH(4), .MAX_BURST(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .fifo_full   (fifo_full),
      .fifo_wr_en  (fifo_wr_en),
      .fifo_wr_data(fifo_wr_data),
      .grant_id    (grant_id),
      .busy        (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // each producer presents its next queued word while it has one left
   always_comb begin
      req_valid = '0;
      req_data  = '0;
      for (int i = 0; i < 4; i++) begin
         req_valid[i]         = src_ptr[i] < src_len[i];
         req_data[i*4 +: 4]   = src_data[i][src_ptr[i][3:0]];
      end
   end

   initial begin
      for (int i = 0; i < 4; i++) src_ptr[i] = '0;
      forever begin
         @(negedge clk);
         acc = req_valid & req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < 4; i++) src_ptr[i] = rst ? 5'd0 : src_ptr[i] + 5'(acc[i]);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   initial begin
      logic [5:0] e;
      forever begin
         @(negedge clk);
         if (!rst && fifo_wr_en) begin
            wr_count++;
            if (exp_q.size() == 0) begin
               check("unexpected_write", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               check("beat_id", int'(grant_id), int'(e[5:4]));
               check("beat_data", int'(fifo_wr_data), int'(e[3:0]));
               check("beat_ready", int'(req_ready), 1 << e[5:4]);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load(input int r, input logic [3:0] d);
      src_data[r][src_len[r][3:0]] = d;
      src_len[r] = src_len[r] + 5'd1;
   endtask

   task automatic exp_beat(input int id, input logic [3:0] d);
      exp_q.push_back({2'(id), d});
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      fifo_full = 1'b0;
      for (int i = 0; i < 4; i++) src_len[i] = '0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      tick(1);
   endtask

   initial begin
      passed   = 0;
      total    = 0;
      wr_count = 0;
      do_reset();
      check("rst_busy", busy, 0);
      check("rst_grant_id", grant_id, 0);
      check("rst_ready", req_ready, 0);
      check("rst_wr_en", fifo_wr_en, 0);
      check("rst_wr_data", fifo_wr_data, 0);

      // async reset mid-burst with every requester valid
      for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) load(i, 4'(i * 4 + j + 1));
      exp_beat(0, 4'h1);
      exp_beat(0, 4'h2);
      tick(3);
      check("t1_wr_en_before_rst", fifo_wr_en, 1);
      #2 rst = 1'b1;
      #1;
      check("t1_wr_en", fifo_wr_en, 0);
      check("t1_ready", req_ready, 0);
      check("t1_busy", busy, 0);
      check("t1_grant_id", grant_id, 0);
      check("t1_pending", exp_q.size(), 0);

      // single requester, three beats then release
      do_reset();
      load(2, 4'hA); load(2, 4'hB); load(2, 4'hC);
      exp_beat(2, 4'hA); exp_beat(2, 4'hB); exp_beat(2, 4'hC);
      tick(1);
      check("t2_grant_id", grant_id, 2);
      check("t2_busy", busy, 1);
      tick(4);
      check("t2_idle", busy, 0);
      check("t2_grant_hold", grant_id, 2);
      check("t2_pending", exp_q.size(), 0);

      // fairness with all four requesters valid
      do_reset();
      for (int j = 0; j < 8; j++) load(0, 4'(j + 1));
      load(1, 4'h9); load(1, 4'hA); load(1, 4'hB); load(1, 4'hC);
      load(2, 4'hD); load(2, 4'hE); load(2, 4'hF); load(2, 4'h0);
      load(3, 4'h3); load(3, 4'h6); load(3, 4'h9); load(3, 4'hC);
      for (int j = 0; j < 4; j++) exp_beat(0, 4'(j + 1));
      exp_beat(1, 4'h9); exp_beat(1, 4'hA); exp_beat(1, 4'hB); exp_beat(1, 4'hC);
      exp_beat(2, 4'hD); exp_beat(2, 4'hE); exp_beat(2, 4'hF); exp_beat(2, 4'h0);
      exp_beat(3, 4'h3); exp_beat(3, 4'h6); exp_beat(3, 4'h9); exp_beat(3, 4'hC);
      for (int j = 4; j < 8; j++) exp_beat(0, 4'(j + 1));
      tick(1);
      w0 = wr_count;
      tick(20);
      check("t3_writes_in_20", wr_count - w0, 16);
      check("t3_regrant_0", grant_id, 0);
      check("t3_regrant_busy", busy, 1);
      tick(5);
      check("t3_idle", busy, 0);
      check("t3_pending", exp_q.size(), 0);

      // fifo_full stall after two beats
      do_reset();
      load(1, 4'h1); load(1, 4'h2); load(1, 4'h3); load(1, 4'h4);
      exp_beat(1, 4'h1); exp_beat(1, 4'h2); exp_beat(1, 4'h3); exp_beat(1, 4'h4);
      w0 = wr_count;
      tick(3);
      fifo_full = 1'b1;
      #1;
      check("t4_stall_ready", req_ready, 0);
      check("t4_stall_wr_en", fifo_wr_en, 0);
      check("t4_stall_busy", busy, 1);
      tick(5);
      check("t4_stall_writes", wr_count - w0, 2);
      check("t4_stall_grant", grant_id, 1);
      fifo_full = 1'b0;
      tick(2);
      check("t4_writes", wr_count - w0, 4);
      check("t4_release", busy, 0);
      check("t4_pending", exp_q.size(), 0);

      // early release by requester 3, next search starts at 0
      do_reset();
      load(3, 4'h7); load(3, 4'h8);
      exp_beat(3, 4'h7); exp_beat(3, 4'h8); exp_beat(1, 4'h6); exp_beat(2, 4'h5);
      tick(1);
      check("t5_grant_3", grant_id, 3);
      load(2, 4'h5);
      load(1, 4'h6);
      w0 = wr_count;
      tick(3);
      check("t5_early_idle", busy, 0);
      check("t5_writes", wr_count - w0, 2);
      tick(1);
      check("t5_next_grant", grant_id, 1);
      tick(5);
      check("t5_pending", exp_q.size(), 0);

      // pointer wrap from 3 to 0, then 1
      do_reset();
      load(3, 4'h9);
      exp_beat(3, 4'h9); exp_beat(0, 4'hA); exp_beat(1, 4'hB);
      tick(1);
      load(0, 4'hA);
      load(1, 4'hB);
      tick(3);
      check("t6_wrap_grant_0", grant_id, 0);
      tick(3);
      check("t6_grant_1", grant_id, 1);
      tick(3);
      check("t6_pending", exp_q.size(), 0);
      check("t6_idle", busy, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
